// File: rtl/down_counter.sv
// Programmable down counter with parallel load, count enable, registered
// terminal-count pulse and optional auto-reload from a reload register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | not counting; q holds, en is ignored until the next non-zero load
// RUN   | counting down on en edges; terminal count at q==1
//
// WIDTH is meant to be 2..16.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             done_q, done_d;

  // State, count, reload value and done pulse registers; reset clears all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= ZERO;
      rl_q    <= ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rl_q    <= rl_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load beats counting; done only at a terminal-count edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rl_d    = rl_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = d;
      rl_d    = d;
      state_d = (d != ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = rl_q;
        end else begin
          count_d = ZERO;
          state_d = IDLE;
        end
      end else begin
        // RUN with a zero count is unreachable; fall back to IDLE without
        // borrowing below zero.
        state_d = IDLE;
      end
    end
  end

  // Outputs straight from registers.
  always_comb begin
    q    = count_q;
    done = done_q;
    busy = (state_q == RUN);
  end

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] d;
  logic       en;
  logic       auto_reload;
  logic [3:0] q;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  down_counter #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .d(d),
    .en(en),
    .auto_reload(auto_reload),
    .q(q),
    .done(done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_t7: q=%0d done=%b busy=%b, expected q=0 done=0 busy=0", q, done, busy);
    end
    #5;
    checks++;
    if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_t12: q=%0d done=%b busy=%b, expected q=0 done=0 busy=0", q, done, busy);
    end
    #3;
    reset = 1'b0;
    en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: q=%0d done=%b busy=%b, expected 0 0 0", i, q, done, busy);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    auto_reload = 1'b0;
    en = 1'b1;
    load = 1'b1;
    d = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      checks++;
      if (q !== exp_q[i] || done !== (i == 4) || busy !== (i != 4)) begin
        errors++;
        $display("FAIL one_shot[%0d]: q=%0d done=%b busy=%b, expected q=%0d done=%b busy=%b",
                 i, q, done, busy, exp_q[i], (i == 4), (i != 4));
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_hold[%0d]: q=%0d done=%b busy=%b, expected 0 0 0", i, q, done, busy);
      end
    end
  endtask

  task automatic test_auto_reload();
    int pulses = 0;
    auto_reload = 1'b1;
    en = 1'b1;
    load = 1'b1;
    d = 4'd3;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'd3 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_load: q=%0d done=%b busy=%b, expected q=3 done=0 busy=1", q, done, busy);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done === 1'b1) pulses++;
      checks++;
      if (q !== 4'(3 - (k % 3)) || done !== (k % 3 == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_seq[%0d]: q=%0d done=%b busy=%b, expected q=%0d done=%b busy=1",
                 k, q, done, busy, 3 - (k % 3), (k % 3 == 0));
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL auto_pulses: got %0d expected 4", pulses);
    end
    load = 1'b1;
    d = 4'd0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic       en_pat [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_q  [11] = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    auto_reload = 1'b0;
    en = 1'b0;
    load = 1'b1;
    d = 4'd5;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gate_load: q=%0d busy=%b, expected q=5 busy=1", q, busy);
    end
    for (int i = 0; i < 11; i++) begin
      en = en_pat[i];
      tick();
      checks++;
      if (q !== exp_q[i] || done !== (i == 8)) begin
        errors++;
        $display("FAIL gate[%0d]: q=%0d done=%b, expected q=%0d done=%b", i, q, done, exp_q[i], (i == 8));
      end
    end
  endtask

  task automatic test_edge_values();
    int pulses = 0;
    en = 1'b1;
    auto_reload = 1'b1;
    load = 1'b1;
    d = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0;
      checks++;
      if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL load_zero[%0d]: q=%0d done=%b busy=%b, expected 0 0 0", i, q, done, busy);
      end
    end
    load = 1'b1;
    d = 4'd15;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done === 1'b1) pulses++;
      checks++;
      if (q !== 4'(15 - (k % 15)) || done !== (k % 15 == 0)) begin
        errors++;
        $display("FAIL period15[%0d]: q=%0d done=%b, expected q=%0d done=%b",
                 k, q, done, 15 - (k % 15), (k % 15 == 0));
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL period15_pulses: got %0d expected 2", pulses);
    end
    load = 1'b1;
    d = 4'd1;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'd1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL d1_load: q=%0d done=%b busy=%b, expected q=1 done=0 busy=1", q, done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q !== 4'd1 || done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL d1_cont[%0d]: q=%0d done=%b busy=%b, expected q=1 done=1 busy=1", i, q, done, busy);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (q !== 4'd1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL d1_hold: q=%0d done=%b busy=%b, expected q=1 done=0 busy=1", q, done, busy);
    end
  endtask

  task automatic test_collisions();
    auto_reload = 1'b0;
    en = 1'b1;
    load = 1'b1;
    d = 4'd3;
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd1) begin
      errors++;
      $display("FAIL coll_pre: q=%0d expected 1", q);
    end
    load = 1'b1;
    d = 4'd7;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'd7 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coll_reload: q=%0d done=%b busy=%b, expected q=7 done=0 busy=1", q, done, busy);
    end
    auto_reload = 1'b1;
    load = 1'b1;
    d = 4'd2;
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd2 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coll_ar_reload: q=%0d done=%b busy=%b, expected q=2 done=1 busy=1", q, done, busy);
    end
    auto_reload = 1'b0;
    tick();
    tick();
    checks++;
    if (q !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_ar_clear: q=%0d done=%b busy=%b, expected q=0 done=1 busy=0", q, done, busy);
    end
    tick();
    checks++;
    if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_ar_stop: q=%0d done=%b busy=%b, expected 0 0 0", q, done, busy);
    end
  endtask

  task automatic test_async_reset();
    auto_reload = 1'b0;
    en = 1'b1;
    load = 1'b1;
    d = 4'd8;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: q=%0d busy=%b, expected q=5 busy=1", q, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: q=%0d done=%b busy=%b, expected 0 0 0", q, done, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL areset_idle[%0d]: q=%0d busy=%b, expected q=0 busy=0", i, q, busy);
      end
    end
    load = 1'b1;
    d = 4'd2;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 4'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_reload: q=%0d busy=%b, expected q=2 busy=1", q, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    d = 4'd0;
    en = 1'b0;
    auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_edge_values();
    test_collisions();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Programmable synchronous down counter with parallel load, count enable, terminal-count pulse and optional auto-reload. It is the count-down counterpart of the team's ripple carry up-counter. It turns a loaded value into a delay or a periodic tick for timers and dividers elsewhere in the design. Nominal width is 4 bits, matching the up-counter's q.

## Interface
- WIDTH, 4, counter width in bits (legal 2..16)
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- load  input  1  load d into counter and reload register, start counting
- d  input  WIDTH  start/reload value
- en  input  1  count enable; when 0, counter and state hold
- auto_reload  input  1  1 = reload from register at terminal count and keep running; 0 = stop at 0
- q  output  WIDTH  current count (registered)
- done  output  1  one-cycle pulse, terminal count reached (registered)
- busy  output  1  high while in RUN (decoded from state register)

## Operation
- Internal: reload register rl[WIDTH-1:0]; 1-bit state, IDLE/RUN.
- Reset (async, while reset=1): q=0, rl=0, state=IDLE, done=0, busy=0.
- Per rising edge, priority is load > en > hold.
- load=1, d!=0: q<=d, rl<=d, state<=RUN. en is ignored that cycle.
- load=1, d=0: q<=0, rl<=0, state<=IDLE, no done pulse.
- load=1 while already in RUN: restart from d. Any pending count is discarded.
- RUN, en=1, q>1: q<=q-1.
- RUN, en=1, q==1, auto_reload=1: q<=rl, done<=1, stay RUN.
- RUN, en=1, q==1, auto_reload=0: q<=0, done<=1, state<=IDLE.
- RUN, en=0: q, state and rl hold.
- IDLE: q holds; en has no effect.
- done is 1 only in the cycle after a terminal-count edge, otherwise 0. It is independent of en in that following cycle.
- auto_reload is sampled only at the q==1 edge, so it may change mid-run.
- Arithmetic is unsigned. q never wraps below 0: the 0 -> all-ones borrow is never produced.

## Timing
- Load to first decrement: load at edge N sets q=d after N. The first decrement happens at the first later edge with en=1.
- One-shot delay: with en held high, done is high in the cycle after edge N+d, and q=0 at that point.
- Auto-reload period: with en held high, done pulses every d cycles. q follows d, d-1, ..., 1, d, ...
- Auto-reload with d=1: done is high continuously while en=1. q stays 1.
- busy goes high the cycle after load (d!=0). It goes low in the same cycle done rises, in one-shot mode.
- Reset mid-count takes effect without waiting for clk. After reset deasserts, the block stays IDLE until the next load.
- Simultaneous load and terminal count: load wins and done is not pulsed.

## Test plan
- Reset: assert reset at t=0 for 15 time units, with clk period 10 -> q=0, done=0, busy=0 throughout. Assert reset asynchronously mid-run at q=5 -> q=0 and busy=0 before the next clk edge.
- One-shot: load d=4, auto_reload=0, en=1 -> q goes 4,3,2,1,0; done is high for exactly the one cycle q=0 first appears; busy then drops; q stays 0 for 10 further cycles.
- Auto-reload: load d=3, auto_reload=1, en=1 for 12 cycles -> q goes 3,2,1,3,2,1,...; done pulses every 3 cycles, 4 pulses total.
- Enable gating: load d=5, toggle en 1,0,0,1,... -> q decrements only on en=1 edges; done fires after the 5th enabled edge.
- Edge values: load d=0 -> stays IDLE with no done pulse. Load d=15 with auto_reload=1 -> period of 15 cycles. Load d=1 with auto_reload=1 -> done is continuous.
- Collisions: reload with d=7 at the edge where q==1 -> q=7 and no done pulse. Clear auto_reload mid-run -> the block stops at 0 after the current count.
